// File: rtl/sensor_timing_pkg.sv
// Shared definitions for the sensor timing generator.
//   MODE_*     : 2-bit test-pattern selector values
//   state_t    : frame sequencer state encoding
//   clamp_cfg  : maps a zero timing field to one so every interval lasts at least a cycle
package sensor_timing_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_HRAMP = 2'd1;
    localparam logic [1:0] MODE_VRAMP = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    // Callers cast the result back to their own field width.
    function automatic logic [31:0] clamp_cfg(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/sensor_timing_gen_if.sv
// Video output bundle of the sensor timing generator.
//   fvals/lvals  : frame / line valid
//   datapar_out  : NCH channels of DW bits, channel k at [k*DW +: DW]
//   frame_done   : one-cycle pulse on the last vblank cycle
//   frame_cnt    : completed-frame counter
// master = generator side, slave = consumer side.
interface sensor_timing_gen_if #(
    parameter int NCH = 8,
    parameter int DW  = 12
);
    logic                fvals;
    logic                lvals;
    logic [NCH*DW-1:0]   datapar_out;
    logic                frame_done;
    logic [15:0]         frame_cnt;

    modport master (output fvals, output lvals, output datapar_out,
                    output frame_done, output frame_cnt);
    modport slave  (input fvals, input lvals, input datapar_out,
                    input frame_done, input frame_cnt);
endinterface

// File: rtl/sensor_pattern_gen.sv
// Test-pattern generator: one registered word of NCH pixel channels.
//   clk_rxg, rst_rx_n : clock, synchronous active-low reset
//   mode, const_val   : pattern selector and constant for mode 0
//   pix, ln           : cycle index within the line, line index within the frame
//   lval_next         : line-valid that will be registered alongside this data
//   data_out          : registered pixels, zero whenever the line is not valid
module sensor_pattern_gen
    import sensor_timing_pkg::*;
#(
    parameter int NCH = 8,
    parameter int DW  = 12,
    parameter int CW  = 12
) (
    input  logic              clk_rxg,
    input  logic              rst_rx_n,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     const_val,
    input  logic [CW-1:0]     pix,
    input  logic [CW-1:0]     ln,
    input  logic              lval_next,
    output logic [NCH*DW-1:0] data_out
);

    logic [NCH*DW-1:0] data_d;
    logic [NCH*DW-1:0] data_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0] ch_d;

            always_comb begin
                ch_d = '0;
                if (lval_next) begin
                    case (mode)
                        MODE_CONST: ch_d = const_val;
                        // Casting to DW bits gives the mod 2^DW wrap.
                        MODE_HRAMP: ch_d = DW'(32'(pix) * 32'(NCH) + 32'(gi));
                        MODE_VRAMP: ch_d = DW'(ln);
                        default:    ch_d = {DW{pix[0] ^ ln[0]}};
                    endcase
                end
            end

            assign data_d[gi*DW +: DW] = ch_d;
        end
    endgenerate

    always_ff @(posedge clk_rxg) begin
        if (!rst_rx_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/sensor_timing_gen.sv
// CMOS-sensor timing and test-pattern source.
//   clk_rxg, rst_rx_n : pixel clock, synchronous active-low reset
//   enable            : run request, only acted on at frame boundaries
//   cfg_*             : timing/pattern config, captured into shadow registers
//                       when a frame starts
//   vid               : registered fvals/lvals/datapar_out/frame_done/frame_cnt
// Every output is registered from the current sequencer state, so outputs
// trail the state by one clock.
module sensor_timing_gen
    import sensor_timing_pkg::*;
#(
    parameter int NCH = 8,
    parameter int DW  = 12,
    parameter int CW  = 12
) (
    input  logic                clk_rxg,
    input  logic                rst_rx_n,
    input  logic                enable,
    input  logic [CW-1:0]       cfg_active,
    input  logic [CW-1:0]       cfg_hblank,
    input  logic [CW-1:0]       cfg_lines,
    input  logic [CW-1:0]       cfg_vblank,
    input  logic [1:0]          cfg_mode,
    input  logic [DW-1:0]       cfg_const,
    sensor_timing_gen_if.master vid
);

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, ln_q, ln_d;
    logic [CW-1:0] act_q, act_d, hbl_q, hbl_d, lines_q, lines_d, vbl_q, vbl_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] const_q, const_d;
    logic          fvals_q, fvals_d, lvals_q, lvals_d, frame_done_q, frame_done_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          latch;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ln_d         = ln_q;
        act_d        = act_q;
        hbl_d        = hbl_q;
        lines_d      = lines_q;
        vbl_d        = vbl_q;
        mode_d       = mode_q;
        const_d      = const_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        latch        = 1'b0;

        // ">=" rather than "==" keeps counters from running past their limit.
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    latch   = 1'b1;
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    ln_d    = '0;
                end
            end
            S_ACTIVE: begin
                if (cnt_q >= act_q - ONE) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_HBLANK: begin
                if (cnt_q >= hbl_q - ONE) begin
                    cnt_d = '0;
                    if (ln_q >= lines_q - ONE) begin
                        state_d = S_VBLANK;
                    end else begin
                        ln_d    = ln_q + ONE;
                        state_d = S_ACTIVE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin // S_VBLANK
                if (cnt_q >= vbl_q - ONE) begin
                    cnt_d        = '0;
                    ln_d         = '0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    if (enable) begin
                        latch   = 1'b1;
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        endcase

        // Config is only captured as a frame starts, so mid-frame edits wait.
        if (latch) begin
            act_d   = CW'(clamp_cfg(32'(cfg_active)));
            hbl_d   = CW'(clamp_cfg(32'(cfg_hblank)));
            lines_d = CW'(clamp_cfg(32'(cfg_lines)));
            vbl_d   = CW'(clamp_cfg(32'(cfg_vblank)));
            mode_d  = cfg_mode;
            const_d = cfg_const;
        end

        fvals_d = (state_q == S_ACTIVE) || (state_q == S_HBLANK);
        lvals_d = (state_q == S_ACTIVE);
    end

    always_ff @(posedge clk_rxg) begin
        if (!rst_rx_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ln_q         <= '0;
            act_q        <= ONE;
            hbl_q        <= ONE;
            lines_q      <= ONE;
            vbl_q        <= ONE;
            mode_q       <= MODE_CONST;
            const_q      <= '0;
            fvals_q      <= 1'b0;
            lvals_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ln_q         <= ln_d;
            act_q        <= act_d;
            hbl_q        <= hbl_d;
            lines_q      <= lines_d;
            vbl_q        <= vbl_d;
            mode_q       <= mode_d;
            const_q      <= const_d;
            fvals_q      <= fvals_d;
            lvals_q      <= lvals_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    logic [NCH*DW-1:0] pat_data;

    sensor_pattern_gen #(
        .NCH (NCH),
        .DW  (DW),
        .CW  (CW)
    ) u_pattern (
        .clk_rxg   (clk_rxg),
        .rst_rx_n  (rst_rx_n),
        .mode      (mode_q),
        .const_val (const_q),
        .pix       (cnt_q),
        .ln        (ln_q),
        .lval_next (state_q == S_ACTIVE),
        .data_out  (pat_data)
    );

    assign vid.fvals       = fvals_q;
    assign vid.lvals       = lvals_q;
    assign vid.datapar_out = pat_data;
    assign vid.frame_done  = frame_done_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sensor_timing_gen.sv
module tb_sensor_timing_gen;

    localparam int CW = 12;

    logic          clk_rxg = 1'b0;
    logic          rst_rx_n = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] cfg_active = '0;
    logic [CW-1:0] cfg_hblank = '0;
    logic [CW-1:0] cfg_lines = '0;
    logic [CW-1:0] cfg_vblank = '0;
    logic [1:0]    cfg_mode = '0;
    logic [11:0]   cfg_const = '0;
    logic [3:0]    cfg_const_b;
    logic [7:0]    cfg_const_c;

    assign cfg_const_b = cfg_const[3:0];
    assign cfg_const_c = cfg_const[7:0];

    always #5 clk_rxg = ~clk_rxg;

    sensor_timing_gen_if #(.NCH(8), .DW(12)) vid_a ();
    sensor_timing_gen_if #(.NCH(8), .DW(4))  vid_b ();
    sensor_timing_gen_if #(.NCH(8), .DW(8))  vid_c ();

    sensor_timing_gen #(.NCH(8), .DW(12), .CW(CW)) dut_a (
        .clk_rxg(clk_rxg), .rst_rx_n(rst_rx_n), .enable(enable),
        .cfg_active(cfg_active), .cfg_hblank(cfg_hblank), .cfg_lines(cfg_lines),
        .cfg_vblank(cfg_vblank), .cfg_mode(cfg_mode), .cfg_const(cfg_const), .vid(vid_a));
    sensor_timing_gen #(.NCH(8), .DW(4), .CW(CW)) dut_b (
        .clk_rxg(clk_rxg), .rst_rx_n(rst_rx_n), .enable(enable),
        .cfg_active(cfg_active), .cfg_hblank(cfg_hblank), .cfg_lines(cfg_lines),
        .cfg_vblank(cfg_vblank), .cfg_mode(cfg_mode), .cfg_const(cfg_const_b), .vid(vid_b));
    sensor_timing_gen #(.NCH(8), .DW(8), .CW(CW)) dut_c (
        .clk_rxg(clk_rxg), .rst_rx_n(rst_rx_n), .enable(enable),
        .cfg_active(cfg_active), .cfg_hblank(cfg_hblank), .cfg_lines(cfg_lines),
        .cfg_vblank(cfg_vblank), .cfg_mode(cfg_mode), .cfg_const(cfg_const_c), .vid(vid_c));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame is a flat timeline of lines*(active+hblank)
    // cycles followed by vblank cycles; position t decides every output.
    bit          m_run = 1'b0;
    int          m_t = 0, m_a = 1, m_h = 1, m_l = 1, m_v = 1, m_mode = 0;
    logic [11:0] m_const = '0;
    logic [15:0] m_fc = '0;

    function automatic int clampi(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic logic [95:0] model_pix(input int mode, input logic [11:0] cst,
                                              input int pix, input int ln);
        logic [95:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            case (mode)
                0:       v = int'(cst);
                1:       v = (pix * 8 + k) % 4096;
                2:       v = ln % 4096;
                default: v = (((pix ^ ln) & 1) != 0) ? 4095 : 0;
            endcase
            r[k*12 +: 12] = 12'(v);
        end
        return r;
    endfunction

    task automatic latch_model();
        m_a     = clampi(int'(cfg_active));
        m_h     = clampi(int'(cfg_hblank));
        m_l     = clampi(int'(cfg_lines));
        m_v     = clampi(int'(cfg_vblank));
        m_mode  = int'(cfg_mode);
        m_const = cfg_const;
    endtask

    // One clock: predict from inputs present at the edge, then compare DUT A.
    task automatic step();
        bit          ef, el, ed;
        logic [95:0] edata;
        int          line_len, fr_len, pix, ln;
        ef = 1'b0; el = 1'b0; ed = 1'b0; edata = '0;
        if (!rst_rx_n) begin
            m_run = 1'b0;
            m_fc  = '0;
        end else if (m_run) begin
            line_len = m_a + m_h;
            fr_len   = m_l * line_len;
            if (m_t < fr_len) begin
                ef  = 1'b1;
                pix = m_t % line_len;
                ln  = m_t / line_len;
                if (pix < m_a) begin
                    el    = 1'b1;
                    edata = model_pix(m_mode, m_const, pix, ln);
                end
            end
            if (m_t == fr_len + m_v - 1) begin
                ed   = 1'b1;
                m_fc = m_fc + 16'd1;
                if (enable) begin
                    latch_model();
                    m_t = 0;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_t++;
            end
        end else if (enable) begin
            latch_model();
            m_run = 1'b1;
            m_t   = 0;
        end
        @(posedge clk_rxg);
        #1;
        chk("cycle", 128'({vid_a.fvals, vid_a.lvals, vid_a.frame_done, vid_a.frame_cnt, vid_a.datapar_out}),
            128'({ef, el, ed, m_fc, edata}));
    endtask

    task automatic do_reset();
        rst_rx_n = 1'b0;
        enable   = 1'b0;
        step();
        step();
        rst_rx_n = 1'b1;
    endtask

    task automatic set_cfg(input int a, input int h, input int l, input int v,
                           input int mode, input int cst);
        cfg_active = CW'(a);
        cfg_hblank = CW'(h);
        cfg_lines  = CW'(l);
        cfg_vblank = CW'(v);
        cfg_mode   = 2'(mode);
        cfg_const  = 12'(cst);
    endtask

    task automatic wait_lv(input string name);
        for (int n = 0; n < 64 && !vid_a.lvals; n++) step();
        chk(name, 128'(vid_a.lvals), 128'(1));
    endtask

    typedef struct {
        int a, h, l, v, mode, cst;
        int exp_lv, exp_fv, exp_first_lv, exp_done_at;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   lv, fv, first_lv, done_at, ndone, rises, fi, lv1, lv2, found;
        bit   prev;

        // Single-frame runs: enable is sampled on edge 1, then dropped.
        // Frame period P = lines*(active+hblank)+vblank; frame_done lands on edge 1+P.
        vecs[0] = '{128, 1, 8, 4, 0, 'h98E, 1024, 1032, 2, 1037};
        vecs[1] = '{0, 0, 0, 0, 1, 0, 1, 2, 2, 4};
        vecs[2] = '{4, 2, 3, 5, 2, 0, 12, 18, 2, 24};
        vecs[3] = '{1, 1, 1, 1, 1, 0, 1, 2, 2, 4};
        vecs[4] = '{2, 1, 2, 1, 3, 0, 4, 6, 2, 8};

        // Reset held for 10 cycles with a live config and enable high.
        set_cfg(128, 1, 8, 4, 0, 'h98E);
        rst_rx_n = 1'b0;
        enable   = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("reset_outputs", 128'({vid_a.fvals, vid_a.lvals, vid_a.frame_done, vid_a.frame_cnt, vid_a.datapar_out}), 128'(0));
        $display("reset held 10 cycles, outputs %0h", vid_a.datapar_out);

        for (int r = 0; r < 5; r++) begin
            do_reset();
            set_cfg(vecs[r].a, vecs[r].h, vecs[r].l, vecs[r].v, vecs[r].mode, vecs[r].cst);
            enable = 1'b1;
            lv = 0; fv = 0; first_lv = 0; done_at = 0; ndone = 0;
            for (int n = 1; n <= 1200; n++) begin
                step();
                if (n == 1) enable = 1'b0;
                if (vid_a.lvals) begin
                    lv++;
                    if (first_lv == 0) first_lv = n;
                end
                if (vid_a.fvals) fv++;
                if (vid_a.frame_done) begin
                    ndone++;
                    if (done_at == 0) done_at = n;
                end
                if (done_at != 0 && n >= done_at + 5) break;
            end
            chk("vec_lvals_cycles", 128'(lv), 128'(vecs[r].exp_lv));
            chk("vec_fvals_cycles", 128'(fv), 128'(vecs[r].exp_fv));
            chk("vec_first_lvals_edge", 128'(first_lv), 128'(vecs[r].exp_first_lv));
            chk("vec_frame_done_edge", 128'(done_at), 128'(vecs[r].exp_done_at));
            chk("vec_frame_done_pulses", 128'(ndone), 128'(1));
            chk("vec_frame_cnt", 128'(vid_a.frame_cnt), 128'(1));
            $display("vec %0d: cfg %0d/%0d/%0d/%0d mode %0d lv=%0d fv=%0d done@%0d",
                     r, vecs[r].a, vecs[r].h, vecs[r].l, vecs[r].v, vecs[r].mode, lv, fv, done_at);
        end

        // H-ramp, including DW=4 wrap on DUT B.
        do_reset();
        set_cfg(4, 1, 2, 1, 1, 0);
        enable = 1'b1;
        wait_lv("t2_wait_lvals");
        step();
        step();
        chk("t2_dw4_pix2_ch0", 128'(vid_b.datapar_out[3:0]), 128'(0));
        chk("t2_dw4_pix2_ch1", 128'(vid_b.datapar_out[7:4]), 128'(1));
        step();
        chk("t2_pix3_ch0", 128'(vid_a.datapar_out[11:0]), 128'(24));
        chk("t2_pix3_ch7", 128'(vid_a.datapar_out[95:84]), 128'(31));
        step();
        chk("t2_hblank_data", 128'({vid_a.lvals, vid_a.datapar_out}), 128'(0));
        step();
        chk("t2_line1_lvals", 128'(vid_a.lvals), 128'(1));
        chk("t2_line1_ch0", 128'(vid_a.datapar_out[11:0]), 128'(0));
        chk("t2_line1_ch7", 128'(vid_a.datapar_out[95:84]), 128'(7));
        $display("h-ramp sequence done");

        // Mid-frame config change and enable drop.
        do_reset();
        set_cfg(128, 1, 8, 4, 1, 0);
        enable = 1'b1;
        rises = 0; prev = 1'b0; fi = 0; lv1 = 0; lv2 = 0;
        for (int n = 0; n < 4000 && fi < 2; n++) begin
            step();
            if (vid_a.lvals && !prev) begin
                rises++;
                if (rises == 4)  cfg_active = CW'(64);
                if (rises == 12) enable = 1'b0;
            end
            prev = vid_a.lvals;
            if (vid_a.lvals) begin
                if (fi == 0) lv1++;
                else lv2++;
            end
            if (vid_a.frame_done) fi++;
        end
        chk("t4_two_frames", 128'(fi), 128'(2));
        chk("t4_frame1_lvals", 128'(lv1), 128'(1024));
        chk("t4_frame2_lvals", 128'(lv2), 128'(512));
        lv = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (vid_a.lvals || vid_a.fvals) lv++;
        end
        chk("t4_idle_after_drop", 128'(lv), 128'(0));
        chk("t4_frame_cnt", 128'(vid_a.frame_cnt), 128'(2));
        $display("mid-frame change: frame1 lv=%0d frame2 lv=%0d", lv1, lv2);

        // Reset in the middle of line 2, then a clean restart.
        do_reset();
        set_cfg(128, 1, 8, 4, 2, 0);
        enable = 1'b1;
        rises = 0; prev = 1'b0;
        for (int n = 0; n < 2000 && rises < 3; n++) begin
            step();
            if (vid_a.lvals && !prev) rises++;
            prev = vid_a.lvals;
        end
        for (int n = 0; n < 50; n++) step();
        chk("t5_line2_pix50", 128'({vid_a.lvals, vid_a.datapar_out[11:0]}), 128'({1'b1, 12'd2}));
        rst_rx_n = 1'b0;
        step();
        chk("t5_reset_edge", 128'({vid_a.fvals, vid_a.lvals, vid_a.frame_done, vid_a.frame_cnt, vid_a.datapar_out}), 128'(0));
        rst_rx_n = 1'b1;
        step();
        step();
        chk("t5_restart_line0", 128'({vid_a.lvals, vid_a.datapar_out[11:0]}), 128'({1'b1, 12'd0}));
        done_at = 0;
        for (int n = 0; n < 1100 && done_at == 0; n++) begin
            step();
            if (vid_a.frame_done) done_at = 1;
        end
        chk("t5_clean_frame_done", 128'({done_at[0], vid_a.frame_cnt}), 128'({1'b1, 16'd1}));
        $display("reset mid-line: restarted, frame_cnt=%0d", vid_a.frame_cnt);

        // Checkerboard.
        do_reset();
        set_cfg(2, 1, 2, 1, 3, 0);
        enable = 1'b1;
        wait_lv("t6_wait_lvals");
        chk("t6_l0p0", 128'(vid_a.datapar_out[11:0]), 128'(0));
        step();
        chk("t6_l0p1", 128'(vid_a.datapar_out[95:84]), 128'('hFFF));
        step();
        step();
        chk("t6_l1p0", 128'(vid_a.datapar_out[11:0]), 128'('hFFF));
        step();
        chk("t6_l1p1", 128'(vid_a.datapar_out[11:0]), 128'(0));

        // V-ramp past 256 lines: DW=8 wraps, DW=12 does not.
        do_reset();
        set_cfg(1, 1, 300, 1, 2, 0);
        enable = 1'b1;
        rises = 0; prev = 1'b0; found = 0;
        for (int n = 0; n < 800 && found == 0; n++) begin
            step();
            if (vid_a.lvals && !prev) begin
                if (rises == 256) begin
                    chk("t6_dw8_line256", 128'(vid_c.datapar_out[7:0]), 128'(0));
                    chk("t6_dw12_line256", 128'(vid_a.datapar_out[11:0]), 128'('h100));
                    found = 1;
                end
                rises++;
            end
            prev = vid_a.lvals;
        end
        chk("t6_reached_line256", 128'(found), 128'(1));
        $display("checker / v-ramp sequences done");

        // Randomized stimulus against the model.
        do_reset();
        for (int it = 0; it < 60; it++) begin
            int nsteps;
            set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            nsteps = int'($urandom_range(20, 200));
            for (int s = 0; s < nsteps; s++) begin
                if ($urandom_range(0, 9) == 0) enable = !enable;
                if ($urandom_range(0, 7) == 0) cfg_active = CW'($urandom_range(0, 6));
                if ($urandom_range(0, 7) == 0) cfg_mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) cfg_lines = CW'($urandom_range(0, 4));
                rst_rx_n = ($urandom_range(0, 299) != 0);
                step();
            end
            rst_rx_n = 1'b1;
            $display("random run %0d: %0d cycles, frame_cnt=%0d", it, nsteps, vid_a.frame_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
